pwm_svm_sequencer: RTL and testbench
====================================

Name: pwm_svm_sequencer

Overview:
- Controller for the triangle carrier generator of the 2-level SVM inverter path. It owns the carrier enable and sequences the bridge through idle, bootstrap charge, run and fault states.
- Duty words from the SVM calculator arrive over a valid/ready handshake into shadow registers. They are loaded into the active compare registers only at the carrier valley (new_cycle).
- Generates six complementary gate signals per phase (A/B/C high/low) with dead-time insertion.

Parameters:
- CNT_W, 16, width of triangle_count and duty words
- PERIOD, 7999, carrier peak count; duties above it are clamped to it
- DEADTIME, 80, clocks both switches of a leg stay off on a transition (2 us at 40 MHz)
- CHARGE_CYCLES, 10, carrier cycles spent in bootstrap charge

Ports:
- clk  in  1  system clock (40 MHz)
- rst_n  in  1  synchronous reset, active low
- start  in  1  level; request to leave IDLE
- stop  in  1  level; orderly shutdown to IDLE
- fault  in  1  level; hardware trip, highest priority
- fault_clr  in  1  pulse; leave FAULT when fault is low
- new_cycle  in  1  carrier valley pulse from the carrier generator
- triangle_count  in  CNT_W  carrier value from the carrier generator
- carrier_en  out  1  enable to the carrier generator
- duty_a, duty_b, duty_c  in  CNT_W  phase compare values
- duty_valid  in  1  duty words valid
- duty_ready  out  1  shadow register free
- gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl  out  1 each  gate drives
- state_o  out  2  0=IDLE, 1=CHARGE, 2=RUN, 3=FAULT

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - state IDLE, carrier_en 0, all gates 0.
  - Shadow and active duties 0, pending 0, duty_ready 1.
  - Charge counter 0, dead-time counters 0, last-side flags = low.
- All outputs are registered; duty_ready = !pending.
- Priority per cycle: rst_n, then fault, then stop, then start/new_cycle.
- IDLE:
  - carrier_en 0, gates 0.
  - start=1 -> CHARGE; carrier_en goes 1 and the charge counter clears.
- CHARGE:
  - gate_xl=1, gate_xh=0 for all three phases.
  - Each new_cycle increments the charge counter.
  - On the new_cycle where the counter equals CHARGE_CYCLES-1: go to RUN and do a pending shadow load in the same cycle.
- RUN:
  - Per phase, req_x is registered one clock after sampling: req_x = (triangle_count < active_duty_x).
  - active_duty_x = 0 gives a permanent low side; active_duty_x = PERIOD gives high except at the peak.
- Dead time, per phase:
  - When req_x differs from last_side_x: both gates drop to 0 on the next clock and dt_cnt loads DEADTIME.
  - dt_cnt decrements each clock. When it reaches 0, the req_x side asserts and last_side_x updates.
  - The on-edge follows the off-edge by exactly DEADTIME clocks.
  - If req_x reverts during dead time, dt_cnt reloads. Both gates are never 1 simultaneously.
- Entering RUN from CHARGE, last_side = low, so a phase with req=1 takes one dead-time interval first.
- stop=1 in CHARGE or RUN -> IDLE next clock: gates 0, carrier_en 0, pending kept.
- fault=1 in any state -> FAULT next clock: all gates 0, carrier_en 0.
- FAULT: exit to IDLE only when fault_clr=1 and fault=0. fault_clr while fault=1 is ignored.
- Handshake:
  - duty_valid & duty_ready captures duty_a/b/c into shadow, with each value clamped to PERIOD if it exceeds it, and sets pending.
  - On new_cycle in CHARGE or RUN with pending=1: active <= shadow and pending clears. duty_ready returns 1 the next clock.
  - If a capture and new_cycle coincide while pending=0, the word goes to shadow only. It loads at the following new_cycle, with no bypass.
  - duty_valid while duty_ready=0 is held off and the data is not captured.
  - In IDLE/FAULT, shadow still accepts one word; no load occurs.
- Reset mid-RUN forces all reset values on the next clock, including clearing pending.

Test Plan:
1. Reset, then start=1 -> state_o=1, carrier_en=1, gate_al/bl/cl=1. After 10 new_cycle pulses -> state_o=2.
2. Duties A=4000, B=0, C=9000 written before RUN -> C clamped to 7999. B: gate_bl constant 1. A: gate_ah high while triangle<4000. Each gate_ah rise is exactly 80 clocks after a gate_al fall.
3. Write duty_a=2000 mid-cycle -> duty_ready=0 until next new_cycle. A second write is held off. The new compare is visible only after the valley.
4. Force triangle_count to toggle around 4000 every 30 clocks -> dt_cnt keeps reloading. Both phase-A gates stay 0 and are never both 1.
5. fault=1 in RUN -> next clock all gates 0, carrier_en 0, state_o=3. fault_clr with fault=1 stays in 3. fault=0 then fault_clr -> state_o=0.
6. rst_n=0 mid-RUN with pending=1 -> next clock state_o=0, gates 0, duty_ready=1. stop in CHARGE -> IDLE in one clock.

Source files
------------

// File: rtl/pwm_svm_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_svm_sequencer
//
// Sequencer for the 2-level SVM inverter bridge. Owns the triangle carrier
// enable, steps the bridge through IDLE -> CHARGE (bootstrap) -> RUN, traps
// into FAULT on a hardware trip, double-buffers the SVM duty words and drives
// the six gate signals with dead-time insertion.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   start, stop       level requests: leave IDLE / orderly shutdown
//   fault, fault_clr  hardware trip (level) and trip acknowledge (pulse)
//   new_cycle         carrier valley pulse from the carrier generator
//   triangle_count    carrier value from the carrier generator
//   carrier_en        enable to the carrier generator
//   duty_a/b/c        phase compare words, duty_valid/duty_ready handshake
//   gate_xh, gate_xl  high/low side gate drives, phase x in {a, b, c}
//   state_o           0=IDLE, 1=CHARGE, 2=RUN, 3=FAULT
// ---------------------------------------------------------------------------
module pwm_svm_sequencer #(
    parameter int CNT_W         = 16,
    parameter int PERIOD        = 7999,
    parameter int DEADTIME      = 80,
    parameter int CHARGE_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             fault,
    input  logic             fault_clr,
    input  logic             new_cycle,
    input  logic [CNT_W-1:0] triangle_count,
    output logic             carrier_en,
    input  logic [CNT_W-1:0] duty_a,
    input  logic [CNT_W-1:0] duty_b,
    input  logic [CNT_W-1:0] duty_c,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             gate_ah,
    output logic             gate_al,
    output logic             gate_bh,
    output logic             gate_bl,
    output logic             gate_ch,
    output logic             gate_cl,
    output logic [1:0]       state_o
);

    localparam int               DT_W     = $clog2(DEADTIME + 1);
    localparam int               CC_W     = $clog2(CHARGE_CYCLES + 1);
    localparam logic [CNT_W-1:0] PERIOD_V = CNT_W'(PERIOD);
    localparam logic [DT_W-1:0]  DT_LOAD  = DT_W'(DEADTIME);
    localparam logic [CC_W-1:0]  CC_LAST  = CC_W'(CHARGE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHARGE = 2'd1,
        S_RUN    = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t           state;
    logic             pending;
    logic [CC_W-1:0]  charge_cnt;
    logic [CNT_W-1:0] duty_in [3];
    logic [CNT_W-1:0] shadow  [3];
    logic [CNT_W-1:0] active  [3];
    logic [DT_W-1:0]  dt_cnt  [3];
    logic [2:0]       req;        // compare result, one clock behind the carrier
    logic [2:0]       last_side;  // side currently conducting (1 = high)
    logic [2:0]       target;     // side the running dead-time interval leads to
    logic [2:0]       gate_h;
    logic [2:0]       gate_l;

    assign duty_in[0] = duty_a;
    assign duty_in[1] = duty_b;
    assign duty_in[2] = duty_c;

    assign duty_ready = ~pending;
    assign state_o    = state;
    assign gate_ah    = gate_h[0];
    assign gate_al    = gate_l[0];
    assign gate_bh    = gate_h[1];
    assign gate_bl    = gate_l[1];
    assign gate_ch    = gate_h[2];
    assign gate_cl    = gate_l[2];

    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d);
        return (d > PERIOD_V) ? PERIOD_V : d;
    endfunction

    // NOTE: every register here is written with <= so that all of them see the
    // pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            carrier_en <= 1'b0;
            gate_h     <= '0;
            gate_l     <= '0;
            pending    <= 1'b0;
            charge_cnt <= '0;
            req        <= '0;
            last_side  <= '0;
            target     <= '0;
            // NOTE: the duty arrays are only three words each and feed the
            // gate compare directly, so they are reset like any other flop
            // rather than left undefined as a RAM would be.
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                dt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                req[i] <= (triangle_count < active[i]);
            end

            // Shadow capture runs in every state; only the valley load is gated.
            if (duty_valid && !pending) begin
                for (int i = 0; i < 3; i++) begin
                    shadow[i] <= clamp_duty(duty_in[i]);
                end
                pending <= 1'b1;
            end

            if (fault) begin
                state      <= S_FAULT;
                carrier_en <= 1'b0;
                gate_h     <= '0;
                gate_l     <= '0;
            end else if (stop && state != S_FAULT) begin
                state      <= S_IDLE;
                carrier_en <= 1'b0;
                gate_h     <= '0;
                gate_l     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        carrier_en <= 1'b0;
                        gate_h     <= '0;
                        gate_l     <= '0;
                        if (start) begin
                            state      <= S_CHARGE;
                            carrier_en <= 1'b1;
                            gate_l     <= 3'b111;
                            charge_cnt <= '0;
                        end
                    end

                    S_CHARGE: begin
                        gate_h <= '0;
                        gate_l <= 3'b111;
                        // RUN always starts from the low side with no
                        // dead-time interval in flight.
                        last_side <= '0;
                        target    <= '0;
                        for (int i = 0; i < 3; i++) begin
                            dt_cnt[i] <= '0;
                        end
                        if (new_cycle) begin
                            charge_cnt <= charge_cnt + 1'b1;
                            if (pending) begin
                                for (int i = 0; i < 3; i++) begin
                                    active[i] <= shadow[i];
                                end
                                pending <= 1'b0;
                            end
                            if (charge_cnt == CC_LAST) begin
                                state <= S_RUN;
                            end
                        end
                    end

                    S_RUN: begin
                        if (new_cycle && pending) begin
                            for (int i = 0; i < 3; i++) begin
                                active[i] <= shadow[i];
                            end
                            pending <= 1'b0;
                        end
                        for (int i = 0; i < 3; i++) begin
                            if (dt_cnt[i] == '0) begin
                                if (req[i] != last_side[i]) begin
                                    // Break before make: open both switches first.
                                    gate_h[i] <= 1'b0;
                                    gate_l[i] <= 1'b0;
                                    dt_cnt[i] <= DT_LOAD;
                                    target[i] <= req[i];
                                end else begin
                                    gate_h[i] <= last_side[i];
                                    gate_l[i] <= ~last_side[i];
                                end
                            end else if (req[i] != target[i]) begin
                                // Request changed mid-interval: restart the full wait.
                                dt_cnt[i] <= DT_LOAD;
                                target[i] <= req[i];
                            end else if (dt_cnt[i] == DT_W'(1)) begin
                                dt_cnt[i]    <= '0;
                                gate_h[i]    <= target[i];
                                gate_l[i]    <= ~target[i];
                                last_side[i] <= target[i];
                            end else begin
                                dt_cnt[i] <= dt_cnt[i] - 1'b1;
                            end
                        end
                    end

                    S_FAULT: begin
                        carrier_en <= 1'b0;
                        gate_h     <= '0;
                        gate_l     <= '0;
                        // fault is known low here: the branch above took it.
                        if (fault_clr) begin
                            state <= S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_svm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_svm_sequencer
//
// Drives a stepped triangle carrier (or a forced toggle around one compare
// level) into pwm_svm_sequencer, writes duty words, and compares every cycle
// against a behavioural model that derives the outputs from the sequencing,
// handshake and dead-time rules. Literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_pwm_svm_sequencer;

    localparam int CNT_W         = 16;
    localparam int PERIOD        = 7999;
    localparam int DEADTIME      = 80;
    localparam int CHARGE_CYCLES = 10;
    localparam int STEP          = 25;

    logic             clk = 1'b0;
    logic             rst_n, start, stop, fault, fault_clr, new_cycle;
    logic [CNT_W-1:0] triangle_count, duty_a, duty_b, duty_c;
    logic             duty_valid, duty_ready, carrier_en;
    logic             gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
    logic [1:0]       state_o;

    int checks   = 0;
    int failures = 0;

    pwm_svm_sequencer #(
        .CNT_W(CNT_W), .PERIOD(PERIOD), .DEADTIME(DEADTIME), .CHARGE_CYCLES(CHARGE_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fault(fault),
        .fault_clr(fault_clr), .new_cycle(new_cycle), .triangle_count(triangle_count),
        .carrier_en(carrier_en), .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
        .duty_valid(duty_valid), .duty_ready(duty_ready),
        .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh), .gate_bl(gate_bl),
        .gate_ch(gate_ch), .gate_cl(gate_cl), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // ---------------- carrier stimulus ----------------
    int gen_mode = 0;   // 0 = stepped triangle, 1 = toggle around 4000
    initial begin : carrier_gen
        int tri_v;
        int tog;
        bit up;
        tri_v = 0; up = 1'b1; tog = 0;
        triangle_count = '0;
        new_cycle = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (gen_mode == 0) begin
                tog = 0;
                if (up) begin
                    if (tri_v + STEP >= PERIOD) begin tri_v = PERIOD; up = 1'b0; end
                    else tri_v = tri_v + STEP;
                end else begin
                    if (tri_v <= STEP) begin tri_v = 0; up = 1'b1; end
                    else tri_v = tri_v - STEP;
                end
                triangle_count = CNT_W'(tri_v);
                new_cycle = (tri_v == 0);
            end else begin
                triangle_count = ((tog / 30) % 2 == 0) ? CNT_W'(3990) : CNT_W'(4010);
                new_cycle = 1'b0;
                tog++;
            end
        end
    end

    // ---------------- behavioural model ----------------
    bit m_live = 1'b0;
    int m_state, m_cc;
    bit m_cen, m_pend;
    int m_sh [3];
    int m_act[3];
    bit m_req[3];                 // compare result sampled on the previous clock
    bit m_side[3], m_dead[3], m_tgt[3];
    int m_stable[3];              // consecutive samples of m_tgt while dead
    bit e_gh[3], e_gl[3];

    task automatic model_gates(input bit h, input bit l);
        for (int i = 0; i < 3; i++) begin
            e_gh[i] = h; e_gl[i] = l;
        end
    endtask

    task automatic model_step();
        bit nreq[3];
        bit pend0;
        int dv[3];
        if (!rst_n) begin
            m_live = 1'b1; m_state = 0; m_cen = 1'b0; m_pend = 1'b0; m_cc = 0;
            for (int i = 0; i < 3; i++) begin
                m_sh[i] = 0; m_act[i] = 0; m_req[i] = 1'b0; m_side[i] = 1'b0;
                m_dead[i] = 1'b0; m_tgt[i] = 1'b0; m_stable[i] = 0;
            end
            model_gates(1'b0, 1'b0);
            return;
        end
        if (!m_live) return;
        dv[0] = int'(duty_a); dv[1] = int'(duty_b); dv[2] = int'(duty_c);
        for (int i = 0; i < 3; i++) nreq[i] = (int'(triangle_count) < m_act[i]);
        pend0 = m_pend;
        if (duty_valid && !pend0) begin
            for (int i = 0; i < 3; i++) m_sh[i] = (dv[i] > PERIOD) ? PERIOD : dv[i];
            m_pend = 1'b1;
        end
        if (fault) begin
            m_state = 3; m_cen = 1'b0; model_gates(1'b0, 1'b0);
        end else if (stop && m_state != 3) begin
            m_state = 0; m_cen = 1'b0; model_gates(1'b0, 1'b0);
        end else begin
            case (m_state)
                0: begin
                    m_cen = 1'b0; model_gates(1'b0, 1'b0);
                    if (start) begin m_state = 1; m_cen = 1'b1; model_gates(1'b0, 1'b1); m_cc = 0; end
                end
                1: begin
                    model_gates(1'b0, 1'b1);
                    if (new_cycle) begin
                        if (pend0) begin
                            for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
                            m_pend = 1'b0;
                        end
                        if (m_cc == CHARGE_CYCLES - 1) m_state = 2;
                        m_cc++;
                    end
                end
                2: begin
                    if (new_cycle && pend0) begin
                        for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
                        m_pend = 1'b0;
                    end
                    for (int i = 0; i < 3; i++) begin
                        if (!m_dead[i]) begin
                            if (m_req[i] == m_side[i]) begin
                                e_gh[i] = m_side[i]; e_gl[i] = !m_side[i];
                            end else begin
                                m_dead[i] = 1'b1; m_tgt[i] = m_req[i]; m_stable[i] = 1;
                                e_gh[i] = 1'b0; e_gl[i] = 1'b0;
                            end
                        end else begin
                            if (m_req[i] == m_tgt[i]) m_stable[i]++;
                            else begin m_tgt[i] = m_req[i]; m_stable[i] = 1; end
                            // The new side turns on once the request has held
                            // for the whole dead time plus the sample that began it.
                            if (m_stable[i] >= DEADTIME + 1) begin
                                m_side[i] = m_tgt[i]; m_dead[i] = 1'b0;
                                e_gh[i] = m_tgt[i]; e_gl[i] = !m_tgt[i];
                            end
                        end
                    end
                end
                default: begin
                    m_cen = 1'b0; model_gates(1'b0, 1'b0);
                    if (fault_clr) m_state = 0;
                end
            endcase
        end
        if (m_state != 2) begin
            for (int i = 0; i < 3; i++) begin
                m_side[i] = 1'b0; m_dead[i] = 1'b0; m_tgt[i] = 1'b0; m_stable[i] = 0;
            end
        end
        for (int i = 0; i < 3; i++) m_req[i] = nreq[i];
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare and edge monitor ----------------
    int valley_cnt = 0, cyc = 0;
    bit watch2 = 1'b0, watch4 = 1'b0;
    int b_bad = 0, a_rises = 0, a_bad = 0, c_falls = 0, a_on4 = 0;
    int last_al_fall = -100000;
    logic prev_ah = 1'b0, prev_al = 1'b0, prev_ch = 1'b0;

    task automatic compare_step();
        cyc++;
        if (new_cycle) valley_cnt++;
        if (m_live) begin
            check("state_o", 32'(state_o), 32'(m_state));
            check("carrier_en", 32'(carrier_en), 32'(m_cen));
            check("duty_ready", 32'(duty_ready), 32'(!m_pend));
            check("gates", {26'd0, gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl},
                  {26'd0, e_gh[0], e_gl[0], e_gh[1], e_gl[1], e_gh[2], e_gl[2]});
            check("overlap", 32'({gate_ah & gate_al, gate_bh & gate_bl, gate_ch & gate_cl}), 32'd0);
        end
        if (watch2) begin
            if (gate_bl !== 1'b1) b_bad++;
            if (prev_al === 1'b1 && gate_al === 1'b0) last_al_fall = cyc;
            if (prev_ah === 1'b0 && gate_ah === 1'b1) begin
                a_rises++;
                if (cyc - last_al_fall != DEADTIME) a_bad++;
            end
            if (prev_ch === 1'b1 && gate_ch === 1'b0) c_falls++;
        end
        if (watch4 && (gate_ah !== 1'b0 || gate_al !== 1'b0)) a_on4++;
        prev_ah = gate_ah; prev_al = gate_al; prev_ch = gate_ch;
    endtask

    always @(negedge clk) compare_step();

    // ---------------- directed + random sequence ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_valleys(input int n);
        int v0;
        int g;
        v0 = valley_cnt; g = 0;
        while (valley_cnt < v0 + n && g < 20000) begin
            @(negedge clk); #1;
            g++;
        end
        check("valley_wait_in_budget", 32'(g < 20000), 32'd1);
    endtask

    task automatic write_duty(input int a, input int b, input int c);
        duty_a = CNT_W'(a); duty_b = CNT_W'(b); duty_c = CNT_W'(c);
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
    endtask

    task automatic check_gates_off(input string name);
        check(name, 32'({gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        duty_valid = 1'b0; duty_a = '0; duty_b = '0; duty_c = '0;
        repeat (3) tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_carrier_en", 32'(carrier_en), 32'd0);
        check("rst_duty_ready", 32'(duty_ready), 32'd1);
        check_gates_off("rst_gates");
        rst_n = 1'b1;
        tick();

        // Word written in IDLE: C exceeds the peak and must be clamped.
        write_duty(4000, 0, 9000);
        check("idle_capture_ready", 32'(duty_ready), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("charge_state", 32'(state_o), 32'd1);
        check("charge_carrier_en", 32'(carrier_en), 32'd1);
        check("charge_gates", 32'({gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}), 32'b010101);
        wait_valleys(CHARGE_CYCLES);
        tick();
        check("run_after_10_valleys", 32'(state_o), 32'd2);
        check("loaded_in_charge", 32'(duty_ready), 32'd1);

        watch2 = 1'b1;
        wait_valleys(3);
        watch2 = 1'b0;
        check("b_low_side_constant", 32'(b_bad), 32'd0);
        check("a_rise_seen", 32'(a_rises >= 2), 32'd1);
        check("a_deadtime_80", 32'(a_bad), 32'd0);
        check("c_clamped_drops_at_peak", 32'(c_falls >= 1), 32'd1);

        // Mid-cycle write, then a held-off second write.
        wait_valleys(1);
        repeat (100) tick();
        write_duty(2000, 0, 9000);
        check("midcycle_ready_low", 32'(duty_ready), 32'd0);
        duty_a = CNT_W'(100); duty_valid = 1'b1;
        repeat (5) tick();
        duty_valid = 1'b0;
        check("held_off_ready_low", 32'(duty_ready), 32'd0);
        wait_valleys(1);
        tick();
        check("ready_after_load", 32'(duty_ready), 32'd1);
        tick();
        check("second_word_dropped", 32'(duty_ready), 32'd1);

        // Randomised duty traffic, including out-of-range words.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(20, 700)) tick();
            duty_a = CNT_W'($urandom_range(0, 9000));
            duty_b = CNT_W'($urandom_range(0, 9000));
            duty_c = CNT_W'($urandom_range(0, 9000));
            duty_valid = 1'b1;
            repeat ($urandom_range(1, 4)) tick();
            duty_valid = 1'b0;
        end

        // Carrier chattering around phase A's compare level.
        wait_valleys(1);
        tick();
        write_duty(4000, 0, 0);
        wait_valleys(1);
        repeat (5) tick();
        gen_mode = 1;
        repeat (45) tick();
        watch4 = 1'b1;
        repeat (300) tick();
        watch4 = 1'b0;
        gen_mode = 0;
        check("chatter_a_gates_off", 32'(a_on4), 32'd0);

        // Fault trip and clear sequence.
        repeat (20) tick();
        fault = 1'b1; tick();
        check("fault_state", 32'(state_o), 32'd3);
        check("fault_carrier_en", 32'(carrier_en), 32'd0);
        check_gates_off("fault_gates");
        fault_clr = 1'b1; tick();
        check("fault_clr_ignored", 32'(state_o), 32'd3);
        fault = 1'b0; fault_clr = 1'b0; tick();
        check("fault_held", 32'(state_o), 32'd3);
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        check("fault_cleared", 32'(state_o), 32'd0);

        // Stop during CHARGE, then reset mid-RUN with a word pending.
        start = 1'b1; tick(); start = 1'b0;
        check("restart_charge", 32'(state_o), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_to_idle", 32'(state_o), 32'd0);
        check("stop_carrier_en", 32'(carrier_en), 32'd0);
        check_gates_off("stop_gates");
        start = 1'b1; tick(); start = 1'b0;
        wait_valleys(CHARGE_CYCLES);
        tick();
        check("rerun_state", 32'(state_o), 32'd2);
        repeat (50) tick();
        write_duty(1234, 5000, 7000);
        check("pending_before_reset", 32'(duty_ready), 32'd0);
        rst_n = 1'b0; tick();
        check("midrun_rst_state", 32'(state_o), 32'd0);
        check("midrun_rst_ready", 32'(duty_ready), 32'd1);
        check("midrun_rst_carrier_en", 32'(carrier_en), 32'd0);
        check_gates_off("midrun_rst_gates");
        rst_n = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
